// File: rtl/pipe_m2w_ctl_pkg.sv
// Shared constants and helpers for the MEM->WB pipeline register.
// Stage word order, MSB first: valid, wreg, m2reg, rd, result, dataout.
package pipe_m2w_ctl_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 5;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pipe_m2w_ctl_if.sv
// MEM-side inputs, ID-side compare sources and WB-side outputs of the M2W register.
interface pipe_m2w_ctl_if
  import pipe_m2w_ctl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  // Handshake: mvalid qualifies the MEM entry; there is no ready path -- stall holds
  // every stage and flush clears every valid, with flush taking priority.
  logic          stall;
  logic          flush;
  logic          mvalid;
  logic          mwreg;
  logic          mm2reg;
  logic [AW-1:0] mrd;
  logic [DW-1:0] mresult;
  logic [DW-1:0] mdataout;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;

  logic          wvalid;
  logic          wwreg;
  logic          wm2reg;
  logic [AW-1:0] wrd;
  logic [DW-1:0] wresult;
  logic [DW-1:0] wdataout;
  logic [DW-1:0] wdata;
  logic          wb_we;
  logic          fwd_a;
  logic          fwd_b;
  logic          pending;

  modport master (
    output stall, flush, mvalid, mwreg, mm2reg, mrd, mresult, mdataout, rs, rt,
    input  wvalid, wwreg, wm2reg, wrd, wresult, wdataout, wdata, wb_we, fwd_a, fwd_b, pending
  );

  modport slave (
    input  stall, flush, mvalid, mwreg, mm2reg, mrd, mresult, mdataout, rs, rt,
    output wvalid, wwreg, wm2reg, wrd, wresult, wdataout, wdata, wb_we, fwd_a, fwd_b, pending
  );

endinterface

// File: rtl/pipe_m2w_ctl_stage.sv
// One MEM->WB register stage: clr_v drops only valid, en loads all fields.
module pipe_m2w_ctl_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_en,
  input  logic          i_clr_v,
  input  logic          i_valid,
  input  logic          i_wreg,
  input  logic          i_m2reg,
  input  logic [AW-1:0] i_rd,
  input  logic [DW-1:0] i_result,
  input  logic [DW-1:0] i_dataout,
  output logic          o_valid,
  output logic          o_wreg,
  output logic          o_m2reg,
  output logic [AW-1:0] o_rd,
  output logic [DW-1:0] o_result,
  output logic [DW-1:0] o_dataout
);

  logic          r_valid;
  logic          r_wreg;
  logic          r_m2reg;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_dataout;

  // Flushed entries keep their payload; only valid matters downstream.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid   <= 1'b0;
      r_wreg    <= 1'b0;
      r_m2reg   <= 1'b0;
      r_rd      <= '0;
      r_result  <= '0;
      r_dataout <= '0;
    end else if (i_clr_v) begin
      r_valid   <= 1'b0;
    end else if (i_en) begin
      r_valid   <= i_valid;
      r_wreg    <= i_wreg;
      r_m2reg   <= i_m2reg;
      r_rd      <= i_rd;
      r_result  <= i_result;
      r_dataout <= i_dataout;
    end
  end

  assign o_valid   = r_valid;
  assign o_wreg    = r_wreg;
  assign o_m2reg   = r_m2reg;
  assign o_rd      = r_rd;
  assign o_result  = r_result;
  assign o_dataout = r_dataout;

endmodule

// File: rtl/pipe_m2w_ctl.sv
// MEM->WB pipeline register: DEPTH-stage chain, write-back select, r0 suppression,
// WB->ID forwarding compare and an in-flight indicator for the hazard unit.
module pipe_m2w_ctl
  import pipe_m2w_ctl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         clrn,
  pipe_m2w_ctl_if.slave bus
);

  if (!depth_ok(DEPTH)) begin : g_depth_err
    $error("pipe_m2w_ctl: DEPTH must be in 1..4");
  end

  // Index 0 is the MEM input, index k+1 is the output of stage k.
  logic          w_valid   [0:DEPTH];
  logic          w_wreg    [0:DEPTH];
  logic          w_m2reg   [0:DEPTH];
  logic [AW-1:0] w_rd      [0:DEPTH];
  logic [DW-1:0] w_result  [0:DEPTH];
  logic [DW-1:0] w_dataout [0:DEPTH];
  logic [DEPTH-1:0] w_vbits;
  logic          w_en;
  logic          w_we;
  logic [AW-1:0] w_wrd;

  assign w_en         = ~bus.stall;
  assign w_valid[0]   = bus.mvalid;
  assign w_wreg[0]    = bus.mwreg;
  assign w_m2reg[0]   = bus.mm2reg;
  assign w_rd[0]      = bus.mrd;
  assign w_result[0]  = bus.mresult;
  assign w_dataout[0] = bus.mdataout;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_m2w_ctl_stage #(.DW(DW), .AW(AW)) u_stage (
      .clk       (clk),
      .clrn      (clrn),
      .i_en      (w_en),
      .i_clr_v   (bus.flush),
      .i_valid   (w_valid[k]),
      .i_wreg    (w_wreg[k]),
      .i_m2reg   (w_m2reg[k]),
      .i_rd      (w_rd[k]),
      .i_result  (w_result[k]),
      .i_dataout (w_dataout[k]),
      .o_valid   (w_valid[k+1]),
      .o_wreg    (w_wreg[k+1]),
      .o_m2reg   (w_m2reg[k+1]),
      .o_rd      (w_rd[k+1]),
      .o_result  (w_result[k+1]),
      .o_dataout (w_dataout[k+1])
    );
    assign w_vbits[k] = w_valid[k+1];
  end

  assign w_wrd        = w_rd[DEPTH];
  assign bus.wvalid   = w_vbits[DEPTH-1];
  assign bus.wwreg    = w_wreg[DEPTH];
  assign bus.wm2reg   = w_m2reg[DEPTH];
  assign bus.wrd      = w_wrd;
  assign bus.wresult  = w_result[DEPTH];
  assign bus.wdataout = w_dataout[DEPTH];
  assign bus.wdata    = w_m2reg[DEPTH] ? w_dataout[DEPTH] : w_result[DEPTH];

  // r0 is hardwired zero, so a write to it is neither performed nor forwarded.
  assign w_we      = bus.wvalid & w_wreg[DEPTH] & (w_wrd != '0);
  assign bus.wb_we = w_we;
  assign bus.fwd_a = w_we & (w_wrd == bus.rs);
  assign bus.fwd_b = w_we & (w_wrd == bus.rt);

  if (DEPTH == 1) begin : g_pend_none
    assign bus.pending = 1'b0;
  end else begin : g_pend_or
    assign bus.pending = |w_vbits[DEPTH-2:0];
  end

endmodule

// File: tb/tb_pipe_m2w_ctl.sv
// Bench for pipe_m2w_ctl: DEPTH=1 and DEPTH=3 instances, directed cases plus random traffic.
module tb_pipe_m2w_ctl;

  localparam int W = 38; // {we, rd[4:0], wdata[31:0]}

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  pipe_m2w_ctl_if #(.DW(32), .AW(5)) bus1 ();
  pipe_m2w_ctl_if #(.DW(32), .AW(5)) bus3 ();

  pipe_m2w_ctl #(.DW(32), .AW(5), .DEPTH(1)) dut1 (.clk(clk), .clrn(clrn), .bus(bus1));
  pipe_m2w_ctl #(.DW(32), .AW(5), .DEPTH(3)) dut3 (.clk(clk), .clrn(clrn), .bus(bus3));

  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last3 = '0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_bus(input int sel, input logic st, fl, mv, wr, m2,
                         input logic [4:0] rd, input logic [31:0] res, dout,
                         input logic [4:0] rsv, rtv);
    if (sel == 1) begin
      bus1.stall = st; bus1.flush = fl; bus1.mvalid = mv; bus1.mwreg = wr; bus1.mm2reg = m2;
      bus1.mrd = rd; bus1.mresult = res; bus1.mdataout = dout; bus1.rs = rsv; bus1.rt = rtv;
    end else begin
      bus3.stall = st; bus3.flush = fl; bus3.mvalid = mv; bus3.mwreg = wr; bus3.mm2reg = m2;
      bus3.mrd = rd; bus3.mresult = res; bus3.mdataout = dout; bus3.rs = rsv; bus3.rt = rtv;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wvalid1"}, bus1.wvalid, 0);
    check({tag, "_wdata1"},  bus1.wdata,  0);
    check({tag, "_wrd1"},    bus1.wrd,    0);
    check({tag, "_wb_we1"},  bus1.wb_we,  0);
    check({tag, "_fwd_a1"},  bus1.fwd_a,  0);
    check({tag, "_wvalid3"}, bus3.wvalid, 0);
    check({tag, "_wdata3"},  bus3.wdata,  0);
    check({tag, "_wb_we3"},  bus3.wb_we,  0);
    check({tag, "_fwd_b3"},  bus3.fwd_b,  0);
    check({tag, "_pend3"},   bus3.pending, 0);
  endtask

  // One clock of stimulus on instance sel (the other idles with bubbles), then scoreboard checks.
  task automatic drive(input int sel, input logic st, fl, mv, wr, m2,
                       input logic [4:0] rd, input logic [31:0] res, dout,
                       input logic [4:0] rsv, rtv, input int exp_wv, input int exp_pend);
    logic [W-1:0]  e;
    logic [W-1:0]  last;
    logic          adv;
    logic          o_wv, o_we, o_fa, o_fb, o_pend;
    logic [4:0]    o_rd;
    logic [31:0]   o_data;
    int            qsize;
    set_bus(sel, st, fl, mv, wr, m2, rd, res, dout, rsv, rtv);
    set_bus(sel == 1 ? 3 : 1, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    adv = !st && !fl;
    e   = {wr && (rd != 5'd0), rd, (m2 ? dout : res)};
    if (adv && mv) begin
      if (sel == 1) exp_q1.push_back(e); else exp_q3.push_back(e);
    end
    @(posedge clk);
    if (fl) begin
      if (sel == 1) exp_q1.delete(); else exp_q3.delete();
    end
    @(negedge clk);
    if (sel == 1) begin
      o_wv = bus1.wvalid; o_we = bus1.wb_we; o_fa = bus1.fwd_a; o_fb = bus1.fwd_b;
      o_pend = bus1.pending; o_rd = bus1.wrd; o_data = bus1.wdata;
      qsize = exp_q1.size(); last = last1;
    end else begin
      o_wv = bus3.wvalid; o_we = bus3.wb_we; o_fa = bus3.fwd_a; o_fb = bus3.fwd_b;
      o_pend = bus3.pending; o_rd = bus3.wrd; o_data = bus3.wdata;
      qsize = exp_q3.size(); last = last3;
    end
    if (exp_wv >= 0)   check("wvalid", o_wv, exp_wv[0]);
    if (exp_pend >= 0) check("pending", o_pend, exp_pend[0]);
    if (adv) begin
      if (o_wv && qsize == 0) begin
        check("unexpected_wvalid", o_wv, 0);
      end else if (o_wv) begin
        if (sel == 1) last = exp_q1.pop_front(); else last = exp_q3.pop_front();
        check("wdata", o_data, last[31:0]);
        check("wrd",   o_rd,   last[36:32]);
        check("wb_we", o_we,   last[37]);
        check("fwd_a", o_fa,   last[37] && (last[36:32] == rsv));
        check("fwd_b", o_fb,   last[37] && (last[36:32] == rtv));
      end else begin
        check("bubble_we",    o_we, 0);
        check("bubble_fwd_a", o_fa, 0);
        check("bubble_fwd_b", o_fb, 0);
      end
    end else if (!fl) begin
      if (o_wv) begin
        check("stall_wdata", o_data, last[31:0]);
        check("stall_wrd",   o_rd,   last[36:32]);
        check("stall_fwd_a", o_fa,   last[37] && (last[36:32] == rsv));
      end else begin
        check("stall_we", o_we, 0);
      end
    end else begin
      check("flush_wvalid", o_wv, 0);
      check("flush_we",     o_we, 0);
    end
    if (sel == 1) last1 = last; else last3 = last;
  endtask

  task automatic random_run(input int sel, input int n);
    logic st, fl, mv, wr, m2;
    logic [4:0] rd, rsv, rtv;
    for (int i = 0; i < n; i++) begin
      st  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      mv  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 4) != 0);
      m2  = $urandom_range(0, 1);
      rd  = 5'($urandom_range(0, 4));
      rsv = 5'($urandom_range(0, 4));
      rtv = 5'($urandom_range(0, 4));
      drive(sel, st, fl, mv, wr, m2, rd, $urandom, $urandom, rsv, rtv, -1, (sel == 1) ? 0 : -1);
    end
    for (int i = 0; i < ((sel == 1) ? 3 : 5); i++)
      drive(sel, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, -1, -1);
    check("leftover_entries", (sel == 1) ? exp_q1.size() : exp_q3.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held across edges with busy inputs, then asynchronous assertion mid-cycle.
    clrn = 1'b0;
    set_bus(1, 0, 0, 1, 1, 1, 5'd6, 32'h1111, 32'h2222, 5'd6, 5'd6);
    set_bus(3, 0, 0, 1, 1, 1, 5'd6, 32'h1111, 32'h2222, 5'd6, 5'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    clrn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_wvalid1", bus1.wvalid, 1);
    check("pre_rst_wvalid3", bus3.wvalid, 1);
    check("pre_rst_pend3",   bus3.pending, 1);
    #2 clrn = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    set_bus(1, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    set_bus(3, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

    // DEPTH=1 directed
    drive(1, 0, 0, 1, 1, 0, 5'd5, 32'h1234,     32'h0,        5'd5, 5'd0, 1, 0);
    drive(1, 0, 0, 1, 1, 1, 5'd7, 32'h1,        32'hDEADBEEF, 5'd0, 5'd7, 1, 0);
    drive(1, 0, 0, 1, 1, 0, 5'd0, 32'h55,       32'h0,        5'd0, 5'd0, 1, 0);
    drive(1, 0, 0, 1, 1, 0, 5'd9, 32'hABCD,     32'h0,        5'd9, 5'd9, 1, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 0, 1, 1, 0, 5'd3, 32'hFFFF, 32'hEEEE, 5'd9, 5'd9, 1, 0);
    drive(1, 1, 1, 1, 1, 0, 5'd4, 32'h77,       32'h0,        5'd4, 5'd4, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 5'd4, 32'h77,       32'h0,        5'd4, 5'd4, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 5'd8, 32'h88,       32'h0,        5'd8, 5'd8, 1, 0);

    // DEPTH=3 directed: rd 1,2,3 reach WB on edges 3,4,5
    drive(3, 0, 0, 1, 1, 0, 5'd1, 32'h11, 32'h0, 5'd1, 5'd2, 0, 1);
    drive(3, 0, 0, 1, 1, 0, 5'd2, 32'h22, 32'h0, 5'd1, 5'd2, 0, 1);
    drive(3, 0, 0, 1, 1, 0, 5'd3, 32'h33, 32'h0, 5'd1, 5'd2, 1, 1);
    drive(3, 0, 0, 0, 0, 0, 5'd0, 32'h0,  32'h0, 5'd1, 5'd2, 1, 1);
    drive(3, 0, 0, 0, 0, 0, 5'd0, 32'h0,  32'h0, 5'd3, 5'd2, 1, 0);
    drive(3, 0, 0, 0, 0, 0, 5'd0, 32'h0,  32'h0, 5'd0, 5'd0, 0, 0);
    drive(3, 0, 0, 1, 1, 0, 5'd4, 32'h44, 32'h0, 5'd0, 5'd0, 0, 1);
    drive(3, 0, 0, 1, 1, 0, 5'd5, 32'h55, 32'h0, 5'd0, 5'd0, 0, 1);
    drive(3, 0, 1, 1, 1, 0, 5'd6, 32'h66, 32'h0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(3, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd4, 0, 0);

    random_run(1, 200);
    random_run(3, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
